ship_placer: RTL
================

// Module: ship_placer
// PURPOSE
//  Interactive ship-placement stage, directly downstream of the main game FSM. While the main FSM holds
//  placeShips high, the player steers a cursor over a 10x10 grid with KEY/switch inputs, rotates and commits
//  ships one at a time. Each commit is bounds- and overlap-checked cell by cell, then written to an occupancy map.
//  Produces grid_occ for the game/draw stages and placement_done for the main FSM.
// PARAMETERS
//  GRID_W     10  grid columns; cell index = y*GRID_W + x
//  GRID_H     10  grid rows
//  NUM_SHIPS  5   ships per player; lengths from battleship_pkg SHIP_LEN table = {5,4,3,3,2}
// PORTS
//  CLOCK_50        in   1    system clock
//  resetn          in   1    asynchronous active-low reset
//  place_ships     in   1    level enable from the main FSM (its placeShips output)
//  move_n          in   4    raw active-low buttons {up,down,left,right}
//  rotate_n        in   1    raw active-low button; toggles orientation
//  commit_n        in   1    raw active-low button; place current ship
//  cursor_x        out  4    cursor column 0..GRID_W-1
//  cursor_y        out  4    cursor row 0..GRID_H-1
//  orient          out  1    0 = horizontal (+x), 1 = vertical (+y)
//  ship_idx        out  3    index of ship being placed, 0..NUM_SHIPS
//  ship_len        out  3    SHIP_LEN[ship_idx]; 0 when ship_idx==NUM_SHIPS
//  place_err       out  1    1-cycle pulse: commit rejected (bounds or overlap)
//  grid_occ        out  100  occupancy bitmap, bit y*GRID_W+x
//  placement_done  out  1    level; all ships placed
// BEHAVIOUR
//  Reset: state IDLE; cursor_x/y=0, orient=0, ship_idx=0, grid_occ=0, place_err=0, placement_done=0.
//  Inputs: each button -> 2-flop synchronizer -> press pulse on synced 1->0 edge (3-cycle latency); one pulse/press.
//  FSM states IDLE, EDIT, CHECK, WRITE, DONE:
//   IDLE : place_ships==1 -> EDIT; same edge clears grid_occ, ship_idx, cursor, orient.
//   EDIT : per cycle at most one action, priority commit > rotate > up > down > left > right; others dropped.
//          moves clamp: up at y=0 / down at y=GRID_H-1 / left at x=0 / right at x=GRID_W-1 -> no change.
//          commit -> CHECK, cell counter k=0.
//   CHECK: one cell per cycle at (x+k,y) or (x,y+k). Out of grid or grid_occ bit set -> place_err=1 for
//          one cycle, return to EDIT, grid unchanged. k==ship_len-1 and clean -> WRITE, k=0.
//          Latency: clean check = ship_len cycles; failure exits on the failing cell.
//   WRITE: set one cell bit per cycle, ship_len cycles; then ship_idx+1; ship_idx==NUM_SHIPS -> DONE, else EDIT.
//          cursor and orient retained.
//   DONE : placement_done=1; buttons ignored; grid_occ held. place_ships low -> IDLE, grid_occ retained.
//  Abort: place_ships low in EDIT/CHECK/WRITE -> IDLE next cycle, grid_occ and ship_idx cleared,
//         partial writes discarded.
//  Buttons ignored outside EDIT; presses during CHECK/WRITE are dropped, not queued.
//  Arithmetic: x+k, y+k computed at 5 bits before the bounds compare (no wrap); index at 7 bits.
//  resetn low at any time -> reset values immediately (async), regardless of state.
// STRUCTURE
//  battleship_pkg (shared header): GRID_W, GRID_H, NUM_SHIPS, SHIP_LEN table, cell-index function,
//   placer state encoding.
//  Sub-module key_press_sync: 2-flop sync + falling-edge pulse, one instance per button
//   (also reused by the game-phase targeting logic).
// TESTING
//  1 reset, place_ships=1, commit at (0,0) H -> 5 CHECK + 5 WRITE cycles; grid_occ bits 0..4 set; ship_idx=1.
//  2 ship0 (len 5), 7 right presses, commit H -> place_err pulses once at k=3 (x=10); grid_occ=0; ship_idx=0; EDIT.
//  3 ship0 at (0,0) H; then ship1 (len 4) at (2,0) V -> place_err on k=0 (cell 2); grid popcount stays 5.
//  4 ships at rows 0..4, x=0, H -> placement_done=1; popcount 17; further buttons do not change outputs;
//    place_ships=0 -> IDLE, grid retained.
//  5 12 left presses from x=0 -> x stays 0; 12 right -> x=9; commit+right in same cycle -> commit taken, x unchanged.
//  6 drop place_ships mid-WRITE -> IDLE next cycle; grid_occ=0, ship_idx=0, placement_done=0;
//    resetn pulse mid-CHECK -> all outputs at reset values.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared battleship constants: grid geometry, fleet table, cell indexing and placer state encoding.
package battleship_pkg;

    localparam logic [4:0] GRID_W    = 5'd10;
    localparam logic [4:0] GRID_H    = 5'd10;
    localparam logic [3:0] X_MAX     = 4'd9;
    localparam logic [3:0] Y_MAX     = 4'd9;
    localparam logic [2:0] NUM_SHIPS = 3'd5;
    localparam int         NUM_CELLS = 100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } placer_state_t;

    // Fleet length table; index NUM_SHIPS and beyond means "no ship".
    function automatic logic [2:0] ship_len_f(input logic [2:0] idx);
        logic [2:0] len;
        case (idx)
            3'd0:    len = 3'd5;
            3'd1:    len = 3'd4;
            3'd2:    len = 3'd3;
            3'd3:    len = 3'd3;
            3'd4:    len = 3'd2;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

    function automatic logic [6:0] cell_idx(input logic [4:0] x, input logic [4:0] y);
        logic [6:0] idx;
        idx = ({2'b00, y} * 7'd10) + {2'b00, x};
        return idx;
    endfunction

endpackage

// File: rtl/key_press_sync.sv
// Two-flop synchronizer for an active-low button plus a one-cycle pulse on each synced press.
module key_press_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and previous-level history; idle level is released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_key_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_press = r_prev & ~r_sync;

endmodule

// File: rtl/ship_placer.sv
// Interactive ship placement: cursor/rotate editing, cell-by-cell commit check, then serial grid write.
module ship_placer
    import battleship_pkg::*;
(
    input  logic         CLOCK_50,
    input  logic         resetn,
    input  logic         place_ships,
    input  logic [3:0]   move_n,
    input  logic         rotate_n,
    input  logic         commit_n,
    output logic [3:0]   cursor_x,
    output logic [3:0]   cursor_y,
    output logic         orient,
    output logic [2:0]   ship_idx,
    output logic [2:0]   ship_len,
    output logic         place_err,
    output logic [99:0]  grid_occ,
    output logic         placement_done
);

    placer_state_t r_state, w_state_nxt;
    logic [3:0]  r_x, w_x_nxt, r_y, w_y_nxt;
    logic        r_orient, w_orient_nxt;
    logic [2:0]  r_ship_idx, w_ship_idx_nxt, r_k, w_k_nxt;
    logic [NUM_CELLS-1:0] r_grid, w_grid_nxt;
    logic        r_err, w_err_nxt, r_done, w_done_nxt;

    logic [3:0]  w_move;
    logic        w_rotate, w_commit;
    logic [2:0]  w_len;
    logic [4:0]  w_cx, w_cy;
    logic [6:0]  w_idx;
    logic        w_inb, w_hit, w_last;

    for (genvar g = 0; g < 4; g++) begin : g_move_sync
        key_press_sync u_move (.clk(CLOCK_50), .rst_n(resetn), .i_key_n(move_n[g]), .o_press(w_move[g]));
    end
    key_press_sync u_rotate (.clk(CLOCK_50), .rst_n(resetn), .i_key_n(rotate_n), .o_press(w_rotate));
    key_press_sync u_commit (.clk(CLOCK_50), .rst_n(resetn), .i_key_n(commit_n), .o_press(w_commit));

    // Cell under test is cursor plus k along the current orientation, widened so it never wraps.
    assign w_len  = ship_len_f(r_ship_idx);
    assign w_cx   = {1'b0, r_x} + (r_orient ? 5'd0 : {2'b00, r_k});
    assign w_cy   = {1'b0, r_y} + (r_orient ? {2'b00, r_k} : 5'd0);
    assign w_inb  = (w_cx < GRID_W) && (w_cy < GRID_H);
    assign w_idx  = cell_idx(w_cx, w_cy);
    assign w_hit  = w_inb ? r_grid[w_idx] : 1'b0;
    assign w_last = (r_k == (w_len - 3'd1));

    // Next-state and datapath decode; leaving place_ships low outside IDLE/DONE aborts the session.
    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_orient_nxt   = r_orient;
        w_ship_idx_nxt = r_ship_idx;
        w_k_nxt        = r_k;
        w_grid_nxt     = r_grid;
        w_err_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (place_ships) begin
                    w_state_nxt    = ST_EDIT;
                    w_grid_nxt     = '0;
                    w_ship_idx_nxt = 3'd0;
                    w_x_nxt        = 4'd0;
                    w_y_nxt        = 4'd0;
                    w_orient_nxt   = 1'b0;
                    w_k_nxt        = 3'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EDIT, ST_CHECK, ST_WRITE: begin
                if (!place_ships) begin
                    w_state_nxt    = ST_IDLE;
                    w_grid_nxt     = '0;
                    w_ship_idx_nxt = 3'd0;
                    w_k_nxt        = 3'd0;
                end else if (r_state == ST_EDIT) begin
                    if (w_commit) begin
                        w_state_nxt = ST_CHECK;
                        w_k_nxt     = 3'd0;
                    end else if (w_rotate) begin
                        w_orient_nxt = ~r_orient;
                    end else if (w_move[3]) begin
                        w_y_nxt = (r_y != 4'd0) ? (r_y - 4'd1) : r_y;
                    end else if (w_move[2]) begin
                        w_y_nxt = (r_y != Y_MAX) ? (r_y + 4'd1) : r_y;
                    end else if (w_move[1]) begin
                        w_x_nxt = (r_x != 4'd0) ? (r_x - 4'd1) : r_x;
                    end else if (w_move[0]) begin
                        w_x_nxt = (r_x != X_MAX) ? (r_x + 4'd1) : r_x;
                    end else begin
                        w_state_nxt = ST_EDIT;
                    end
                end else if (r_state == ST_CHECK) begin
                    if (!w_inb || w_hit) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_EDIT;
                        w_k_nxt     = 3'd0;
                    end else if (w_last) begin
                        w_state_nxt = ST_WRITE;
                        w_k_nxt     = 3'd0;
                    end else begin
                        w_k_nxt = r_k + 3'd1;
                    end
                end else begin
                    w_grid_nxt[w_idx] = 1'b1;
                    if (w_last) begin
                        w_k_nxt        = 3'd0;
                        w_ship_idx_nxt = r_ship_idx + 3'd1;
                        w_state_nxt    = ((r_ship_idx + 3'd1) == NUM_SHIPS) ? ST_DONE : ST_EDIT;
                    end else begin
                        w_k_nxt = r_k + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!place_ships) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_x        <= 4'd0;
            r_y        <= 4'd0;
            r_orient   <= 1'b0;
            r_ship_idx <= 3'd0;
            r_k        <= 3'd0;
            r_grid     <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_orient   <= w_orient_nxt;
            r_ship_idx <= w_ship_idx_nxt;
            r_k        <= w_k_nxt;
            r_grid     <= w_grid_nxt;
            r_err      <= w_err_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign cursor_x       = r_x;
    assign cursor_y       = r_y;
    assign orient         = r_orient;
    assign ship_idx       = r_ship_idx;
    assign ship_len       = w_len;
    assign place_err      = r_err;
    assign grid_occ       = r_grid;
    assign placement_done = r_done;

endmodule
